// File: rtl/mag_cmp_pkg.sv
// Shared constants and types for the 2-bit magnitude comparator tile.
package mag_cmp_pkg;

  localparam int OPW    = 2;
  localparam int RESW   = 3;
  localparam int GT_IDX = 0;
  localparam int EQ_IDX = 1;
  localparam int LT_IDX = 2;
  localparam int CNT_W  = 8;

  typedef logic [OPW-1:0]   opnd_t;
  typedef logic [RESW-1:0]  res_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/mag_cmp2.sv
// Combinational unsigned compare producing one-hot {lt, eq, gt}.
import mag_cmp_pkg::*;

module mag_cmp2 (
  input  logic [OPW-1:0]  a_i,
  input  logic [OPW-1:0]  b_i,
  output logic [RESW-1:0] res_o
);

  always_comb begin
    res_o         = '0;
    res_o[GT_IDX] = (a_i > b_i);
    res_o[EQ_IDX] = (a_i == b_i);
    res_o[LT_IDX] = (a_i < b_i);
  end

endmodule

// File: rtl/tt_um_bmsce_project_1.sv
// Tile wrapper: compare flags, registered flags, change strobe.
// MISMATCH_COUNT_EN adds a saturating A!=B counter on uio_out.
import mag_cmp_pkg::*;

module tt_um_bmsce_project_1 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  res_t cmp;
  res_t flags_q;
  res_t flags_d;
  logic strobe_q;
  logic strobe_d;
  logic unused_in;

  assign unused_in = ^{ui_in[7:4], uio_in};

  mag_cmp2 u_cmp (
    .a_i   (ui_in[1:0]),
    .b_i   (ui_in[3:2]),
    .res_o (cmp)
  );

  // Reset flags are 000, so the first load always strobes.
  always_comb begin
    flags_d  = flags_q;
    strobe_d = 1'b0;
    if (ena) begin
      flags_d  = cmp;
      strobe_d = (cmp != flags_q);
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      flags_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      strobe_q <= strobe_d;
    end
  end

  assign uo_out = {1'b0, strobe_q, flags_q, cmp};

`ifdef MISMATCH_COUNT_EN
  cnt_t cnt_q;
  cnt_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ena && !cmp[EQ_IDX] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign uio_out = cnt_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_bmsce_project_1.sv
// Directed self-checking bench for tt_um_bmsce_project_1.
module tb_tt_um_bmsce_project_1;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int n_run;
  int n_fail;

  tt_um_bmsce_project_1 dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] flags(input int a, input int b);
    if (a > b)       return 8'h01;
    else if (a == b) return 8'h02;
    else             return 8'h04;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] iv;
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #3;
    check("reset_uo", uo_out, 8'h02);
    check("reset_uio", uio_out, 8'h00);
`ifdef MISMATCH_COUNT_EN
    check("reset_oe", uio_oe, 8'hFF);
`else
    check("reset_oe", uio_oe, 8'h00);
`endif

    // sweep with reset held
    ena = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        ui_in = 8'((b << 2) | a);
        #10;
        check("rst_cmb", {5'b0, uo_out[2:0]}, flags(a, b));
        check("rst_reg", {3'b0, uo_out[7:3]}, 8'h00);
        check("rst_cnt", uio_out, 8'h00);
      end
    end

    // sweep running
    rst_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        ui_in = 8'((b << 2) | a);
        #10;
        check("run_cmb", {5'b0, uo_out[2:0]}, flags(a, b));
      end
    end
    ui_in = 8'h07; #2;
    check("ex_3_1", {5'b0, uo_out[2:0]}, 8'h01);
    ui_in = 8'h0A; #2;
    check("ex_2_2", {5'b0, uo_out[2:0]}, 8'h02);
    ui_in = 8'h0C; #2;
    check("ex_0_3", {5'b0, uo_out[2:0]}, 8'h04);

    // latency and strobe
    step();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    ui_in = 8'h01;
    ena   = 1'b1;
    step();
    check("lat_load", uo_out, 8'h49);
    step();
    check("lat_hold", uo_out, 8'h09);

    // enable gating
    ui_in = 8'h0A;
    step();
    check("en_load", uo_out, 8'h52);
    step();
    check("en_same", uo_out, 8'h12);
    ena   = 1'b0;
    ui_in = 8'h04;
    #1;
    check("en_cmb", uo_out, 8'h14);
    repeat (3) begin
      step();
      check("en_gate", uo_out, 8'h14);
    end
    ena = 1'b1;
    step();
    check("en_resume", uo_out, 8'h64);

    // async reset mid-operation
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst", uo_out, 8'h04);
    step();
    check("rst_hold", uo_out, 8'h04);
    rst_n = 1'b0;
    step();
    check("post_rst", uo_out, 8'h64);

    // input isolation
    ui_in = 8'h07;
    step();
    check("iso_load", uo_out, 8'h49);
    step();
    check("iso_base", uo_out, 8'h09);
    ena = 1'b0;
    for (int i = 0; i < 256; i++) begin
      iv     = 8'(i);
      ui_in  = {iv[7:4], 4'h7};
      uio_in = iv;
      #3;
      check("iso_uo", uo_out, 8'h09);
`ifndef MISMATCH_COUNT_EN
      check("iso_uio", uio_out, 8'h00);
`endif
    end
    uio_in = 8'h00;
    ui_in  = 8'h07;

`ifdef MISMATCH_COUNT_EN
    step();
    rst_n = 1'b1;
    #1;
    check("cnt_clr", uio_out, 8'h00);
    rst_n = 1'b0;
    ui_in = 8'h09;
    ena   = 1'b1;
    repeat (5) step();
    check("cnt_5", uio_out, 8'h05);
    repeat (295) step();
    check("cnt_sat", uio_out, 8'hFF);
    check("cnt_oe", uio_oe, 8'hFF);
    #2;
    rst_n = 1'b1;
    #1;
    check("cnt_rst", uio_out, 8'h00);
    check("cnt_rst_uo", uo_out, 8'h04);
    rst_n = 1'b0;
`else
    ui_in = 8'h09;
    ena   = 1'b1;
    repeat (5) step();
    check("nocnt_uio", uio_out, 8'h00);
    check("nocnt_oe", uio_oe, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
